// File: rtl/uncache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uncache_axi_bridge_pkg
// Brief    : Shared encodings for the uncached AXI bridge (FSM states, AXI
//            burst/response/size codes) and the tag-stage boolean macros.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef True_v
`define True_v 1'b1
`endif

`ifndef False_v
`define False_v 1'b0
`endif

package uncache_axi_bridge_pkg;

  // Bridge FSM state encodings
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WREQ  = 3'd3;
  localparam logic [2:0] S_WRESP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // AXI protocol constants
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

endpackage

`default_nettype wire

// File: rtl/uncache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uncache_axi_bridge
// Brief    : Single-outstanding AXI master for uncached accesses. Runs one
//            single-beat read (AR/R) or write (AW/W/B) per request and returns
//            a one-cycle refresh pulse with the read data / error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uncache_axi_bridge
  import uncache_axi_bridge_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  // Request side (tag stage / execute path)
  input  logic            axi_en,
  input  logic [3:0]      axi_wsel,
  input  logic [31:0]     axi_addr,
  input  logic [31:0]     axi_wdata,
  input  logic [1:0]      axi_rsize,
  output logic            refresh,
  output logic [31:0]     axi_rdata,
  output logic            axi_err,
  // AR channel
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  // R channel
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AW channel
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  // W channel
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // B channel
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  // Map byte strobes to an AXI transfer size; irregular patterns go out as a word
  function automatic logic [2:0] wsel_to_size(input logic [3:0] wsel);
    case (wsel)
      4'b1111:                            return AXI_SIZE_WORD;
      4'b0011, 4'b1100:                   return AXI_SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return AXI_SIZE_BYTE;
      default:                            return AXI_SIZE_WORD;
    endcase
  endfunction

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_aw_done;
  logic       r_w_done;
  logic       w_aw_done;
  logic       w_w_done;
  logic       w_arvalid_nx;
  logic       w_rready_nx;
  logic       w_awvalid_nx;
  logic       w_wvalid_nx;
  logic       w_bready_nx;
  logic       w_refresh_nx;
  logic       w_err_nx;

  // Single-beat transfers always carry rlast; nothing depends on it
  logic w_unused_rlast;
  assign w_unused_rlast = rlast;

  // Fixed single-beat INCR attributes
  assign arid    = '0;
  assign awid    = '0;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = `True_v;

  // AW and W complete independently; the flags remember a handshake until both are in
  assign w_aw_done = (r_state == S_WREQ) && (r_aw_done || (awvalid && awready));
  assign w_w_done  = (r_state == S_WREQ) && (r_w_done  || (wvalid  && wready));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_aw_done <= `False_v;
      r_w_done  <= `False_v;
    end else begin
      r_state   <= w_next_state;
      r_aw_done <= w_aw_done;
      r_w_done  <= w_w_done;
    end
  end

  // Next-state selection; axi_en only matters in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (axi_en) w_next_state = (|axi_wsel) ? S_WREQ : S_RADDR;
      S_RADDR: if (arready) w_next_state = S_RDATA;
      S_RDATA: if (rvalid) w_next_state = S_DONE;
      S_WREQ:  if (w_aw_done && w_w_done) w_next_state = S_WRESP;
      S_WRESP: if (bvalid) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every handshake signal is a flop
  always_comb begin
    w_arvalid_nx = (w_next_state == S_RADDR);
    w_rready_nx  = (w_next_state == S_RDATA);
    w_awvalid_nx = (w_next_state == S_WREQ) && !w_aw_done;
    w_wvalid_nx  = (w_next_state == S_WREQ) && !w_w_done;
    w_bready_nx  = (w_next_state == S_WRESP);
    w_refresh_nx = (w_next_state == S_DONE);
    w_err_nx     = `False_v;
    if (r_state == S_RDATA && rvalid) w_err_nx = (rresp != AXI_RESP_OKAY);
    if (r_state == S_WRESP && bvalid) w_err_nx = (bresp != AXI_RESP_OKAY);
  end

  // Handshake and completion output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid <= `False_v;
      rready  <= `False_v;
      awvalid <= `False_v;
      wvalid  <= `False_v;
      bready  <= `False_v;
      refresh <= `False_v;
      axi_err <= `False_v;
    end else begin
      arvalid <= w_arvalid_nx;
      rready  <= w_rready_nx;
      awvalid <= w_awvalid_nx;
      wvalid  <= w_wvalid_nx;
      bready  <= w_bready_nx;
      refresh <= w_refresh_nx;
      axi_err <= w_err_nx;
    end
  end

  // Latch request fields on acceptance and read data on the R handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr    <= '0;
      arsize    <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      axi_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && axi_en) begin
        if (|axi_wsel) begin
          awaddr <= axi_addr;
          awsize <= wsel_to_size(axi_wsel);
          wdata  <= axi_wdata;
          wstrb  <= axi_wsel;
        end else begin
          araddr <= axi_addr;
          arsize <= {1'b0, axi_rsize};
        end
      end
      if (r_state == S_RDATA && rvalid) axi_rdata <= rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uncache_axi_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uncache_axi_bridge
// Brief    : Randomized scoreboard bench for uncache_axi_bridge with a
//            delay-programmable AXI slave and a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uncache_axi_bridge;

  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            axi_en = 1'b0;
  logic [3:0]      axi_wsel = '0;
  logic [31:0]     axi_addr = '0;
  logic [31:0]     axi_wdata = '0;
  logic [1:0]      axi_rsize = '0;
  logic            refresh;
  logic [31:0]     axi_rdata;
  logic            axi_err;
  logic [ID_W-1:0] arid, awid;
  logic [31:0]     araddr, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic            arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]      wstrb;
  logic            arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [31:0]     rdata = '0;
  logic [1:0]      rresp = '0, bresp = '0;
  logic            rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  always #5 clk = ~clk;

  uncache_axi_bridge #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .axi_en(axi_en), .axi_wsel(axi_wsel), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_rsize(axi_rsize), .refresh(refresh), .axi_rdata(axi_rdata), .axi_err(axi_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // One expected transaction
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Slave behaviour for the current transaction
  int          d_ar = 0, d_r = 0, d_aw = 0, d_w = 0, d_b = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer size from the byte-enable shape
  function automatic logic [2:0] model_size(input logic [3:0] s);
    if (s == 4'b1111) return 3'd2;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    if ($countones(s) == 1) return 3'd0;
    return 3'd2;
  endfunction

  // AXI slave: each ready/valid is withheld for a programmed number of cycles
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      end else begin
        if (arvalid) begin arready = (ar_c >= d_ar); ar_c++; end
        else begin arready = 0; ar_c = 0; end
        if (rready) begin
          rvalid = (r_c >= d_r); r_c++;
          rdata  = rvalid ? s_rdata : $urandom;
          rresp  = s_resp; rlast = 1'b1;
        end else begin rvalid = 0; r_c = 0; rdata = $urandom; end
        if (awvalid) begin awready = (aw_c >= d_aw); aw_c++; end
        else begin awready = 0; aw_c = 0; end
        if (wvalid) begin wready = (w_c >= d_w); w_c++; end
        else begin wready = 0; w_c = 0; end
        if (bready) begin bvalid = (b_c >= d_b); b_c++; bresp = s_resp; end
        else begin bvalid = 0; b_c = 0; end
      end
    end
  end

  // Monitor: protocol checks on each cycle, scoreboard pop on refresh
  int   ar_hs = 0, aw_hs = 0, w_hs = 0;
  bit   p_ar = 0, p_aw = 0, p_w = 0, p_refresh = 0;
  logic [31:0] p_araddr = '0, p_awaddr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      ar_hs <= 0; aw_hs <= 0; w_hs <= 0;
      p_ar <= 0; p_aw <= 0; p_w <= 0; p_refresh <= 0;
    end else begin
      int nar, naw, nw;
      exp_t e;
      nar = ar_hs; naw = aw_hs; nw = w_hs;
      if (p_ar) begin chk("arvalid_held", arvalid, 1); chk("araddr_stable", araddr, p_araddr); end
      if (p_aw) begin chk("awvalid_held", awvalid, 1); chk("awaddr_stable", awaddr, p_awaddr); end
      if (p_w)  chk("wvalid_held", wvalid, 1);
      if (awvalid) chk("aw_single_beat", aw_hs, 0);
      if (wvalid)  chk("w_single_beat", w_hs, 0);
      if (arvalid && arready) begin
        nar++;
        if (exp_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("ar_is_read", {31'd0, e.wr}, 0);
          chk("araddr", araddr, e.addr);
          chk("arsize", {29'd0, arsize}, {29'd0, e.size});
          chk("ar_const", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01});
        end
      end
      if (awvalid && awready) begin
        naw++;
        if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("aw_is_write", {31'd0, e.wr}, 1);
          chk("awaddr", awaddr, e.addr);
          chk("awsize", {29'd0, awsize}, {29'd0, e.size});
          chk("aw_const", {awid, awlen, awburst}, {4'd0, 8'd0, 2'b01});
        end
      end
      if (wvalid && wready) begin
        nw++;
        if (exp_q.size() == 0) chk("w_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("wdata", wdata, e.wd);
          chk("wstrb", {28'd0, wstrb}, {28'd0, e.strb});
          chk("wlast", {31'd0, wlast}, 1);
        end
      end
      if (bready) chk("bready_after_aw_w", {30'd0, aw_hs == 1, w_hs == 1}, 3);
      if (rready) chk("rready_after_ar", {31'd0, ar_hs == 1}, 1);
      if (refresh) begin
        chk("refresh_one_cycle", {31'd0, p_refresh}, 0);
        if (exp_q.size() == 0) chk("refresh_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.issue, e.lat);
          chk("axi_rdata", axi_rdata, e.rd);
          chk("axi_err", {31'd0, axi_err}, {31'd0, e.err});
          if (e.wr) chk("write_hs_count", {ar_hs[7:0], aw_hs[7:0], w_hs[7:0]}, {8'd0, 8'd1, 8'd1});
          else      chk("read_hs_count", {ar_hs[7:0], aw_hs[7:0], w_hs[7:0]}, {8'd1, 8'd0, 8'd0});
        end
        nar = 0; naw = 0; nw = 0;
      end
      ar_hs <= nar; aw_hs <= naw; w_hs <= nw;
      p_ar <= arvalid && !arready; p_araddr <= araddr;
      p_aw <= awvalid && !awready; p_awaddr <= awaddr;
      p_w  <= wvalid && !wready;
      p_refresh <= refresh;
    end
  end

  // Issue one request, push its expected outcome, hold axi_en until refresh
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [3:0] wsel,
                        input logic [1:0] rsize, input logic [31:0] wd,
                        input int a_dly, input int b_dly, input int c_dly,
                        input logic [31:0] rd, input logic [1:0] resp);
    exp_t e;
    int n;
    @(negedge clk);
    if (wr) begin d_aw = a_dly; d_w = b_dly; d_b = c_dly; end
    else begin d_ar = a_dly; d_r = c_dly; end
    s_rdata = rd; s_resp = resp;
    e.wr = wr; e.addr = addr; e.wd = wd; e.err = (resp != 2'b00);
    e.strb = wr ? wsel : 4'd0;
    e.size = wr ? model_size(wsel) : {1'b0, rsize};
    if (!wr) last_rd = rd;
    e.rd = last_rd;
    e.lat = wr ? 3 + ((a_dly > b_dly) ? a_dly : b_dly) + c_dly : 3 + a_dly + c_dly;
    e.issue = cyc;
    exp_q.push_back(e);
    axi_en = 1'b1; axi_wsel = wr ? wsel : 4'd0; axi_addr = addr;
    axi_rsize = rsize; axi_wdata = wd;
    @(negedge clk);
    axi_addr = $urandom;  // must not affect a request already accepted
    n = 0;
    while (!refresh && n < 200) begin @(negedge clk); n++; end
    chk("refresh_seen", {31'd0, refresh}, 1);
    if (!refresh) exp_q.delete();
    axi_en = 1'b0; axi_addr = $urandom;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [3:0] ws;
    bit wr;
    logic [1:0] resp;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, refresh}, 0);
    chk("rst_err", {31'd0, axi_err}, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_addr", araddr | awaddr | wdata, 0);
    chk("rst_strb_size", {22'd0, wstrb, arsize, awsize}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed scenarios
    do_txn(0, 32'hBFAF_8000, 4'b0000, 2'd2, 32'h0,          0, 0, 0, 32'h1234_5678, 2'b00);
    do_txn(1, 32'hBFD0_F002, 4'b0100, 2'd0, 32'h00AB_0000,  0, 0, 0, 32'h0,         2'b00);
    do_txn(1, 32'hBFD0_0010, 4'b1111, 2'd0, 32'hCAFE_F00D,  3, 0, 0, 32'h0,         2'b00);
    do_txn(1, 32'hBFD0_0020, 4'b0011, 2'd0, 32'h0000_BEEF,  0, 4, 2, 32'h0,         2'b00);
    do_txn(0, 32'hBFAF_8004, 4'b0000, 2'd1, 32'h0,          3, 0, 5, 32'h8765_4321, 2'b00);
    do_txn(1, 32'hBFD0_0030, 4'b1000, 2'd0, 32'hAA00_0000,  0, 0, 1, 32'h0,         2'b10);
    do_txn(0, 32'hBFAF_8008, 4'b0000, 2'd0, 32'h0,          0, 0, 0, 32'h0000_005A, 2'b00);
    do_txn(0, 32'hBFAF_800C, 4'b0000, 2'd2, 32'h0,          1, 0, 0, 32'hDEAD_BEEF, 2'b11);

    // Asynchronous reset while the bridge waits in RDATA
    @(negedge clk);
    d_ar = 0; d_r = 1000; s_rdata = 32'h5555_AAAA; s_resp = 2'b00;
    begin
      exp_t e;
      e.wr = 0; e.addr = 32'h1000_0040; e.strb = 0; e.size = 3'd2; e.wd = 0;
      e.rd = 0; e.err = 0; e.lat = 0; e.issue = cyc;
      exp_q.push_back(e);
    end
    axi_en = 1'b1; axi_wsel = 4'd0; axi_addr = 32'h1000_0040; axi_rsize = 2'd2;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    chk("reached_rdata", {31'd0, rready}, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rready", {31'd0, rready}, 0);
    chk("async_rst_outs", {27'd0, refresh, arvalid, awvalid, wvalid, axi_err}, 0);
    chk("async_rst_regs", araddr | axi_rdata, 0);
    exp_q.delete();
    last_rd = '0;
    axi_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_txn(0, 32'h1000_0044, 4'b0000, 2'd1, 32'h0, 0, 0, 0, 32'h0BAD_F00D, 2'b00);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      wr = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       ws = 4'b1111;
        1:       ws = $urandom_range(0, 1) ? 4'b0011 : 4'b1100;
        2:       ws = 4'b0001 << $urandom_range(0, 3);
        default: ws = 4'($urandom_range(1, 15));
      endcase
      resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(wr, $urandom, ws, 2'($urandom_range(0, 2)), $urandom,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom, resp);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
